// File: rtl/ilm_accumulator.sv
// Signed, saturating accumulator for sign/magnitude products from a log multiplier.
// Runs one dot product of 'len' beats per start and presents the result through a valid/ready handshake.
module ilm_accumulator #(
    parameter int MAG_W = 16,
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             prod_sign,
    input  logic [MAG_W-1:0] prod_mag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             sat,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    logic [ACC_W:0]   mag_ext;
    logic [ACC_W:0]   term;
    logic [ACC_W:0]   sum_wide;
    logic             clamp;
    logic [ACC_W-1:0] sum_clamped;

    // One guard bit is enough: a single term never exceeds the accumulator range.
    always_comb begin
        mag_ext  = {{(ACC_W+1-MAG_W){1'b0}}, prod_mag};
        term     = prod_sign ? -mag_ext : mag_ext;
        sum_wide = {acc_q[ACC_W-1], acc_q} + term;
        clamp    = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        if (!clamp) begin
            sum_clamped = sum_wide[ACC_W-1:0];
        end else if (sum_wide[ACC_W]) begin
            sum_clamped = ACC_MIN;
        end else begin
            sum_clamped = ACC_MAX;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    sat_d = 1'b0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = ACCUM;
                    end else begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = sum_clamped;
                    sat_d = sat_q | clamp;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // Handshake outputs decode straight from state so reset clears them without a clock.
    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = acc_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_ilm_accumulator.sv
// Self-checking bench for ilm_accumulator: directed scenarios plus randomized dot products
// checked against an integer model with per-step clamping.
module tb_ilm_accumulator;

    localparam int MAG_W = 16;
    localparam int ACC_W = 24;
    localparam int LEN_W = 8;
    localparam longint MAXV = (longint'(1) <<< (ACC_W-1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACC_W-1));

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             prod_sign = 1'b0;
    logic [MAG_W-1:0] prod_mag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] result;
    logic             sat;
    logic             busy;

    int total = 0;
    int bad = 0;

    ilm_accumulator #(.MAG_W(MAG_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .prod_sign(prod_sign), .prod_mag(prod_mag),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .sat(sat), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic longint res_val();
        return longint'($signed(result));
    endfunction

    // Reference: exact integer sum, clamped to the accumulator range after every beat.
    function automatic longint model_add(input longint acc, input bit s, input longint m, inout bit sat_flag);
        longint r;
        r = acc + (s ? -m : m);
        if (r > MAXV) begin r = MAXV; sat_flag = 1'b1; end
        else if (r < MINV) begin r = MINV; sat_flag = 1'b1; end
        return r;
    endfunction

    task automatic do_start(input int l);
        @(negedge clk);
        start = 1'b1;
        len = l[LEN_W-1:0];
        @(negedge clk);
        start = 1'b0;
        len = '0;
    endtask

    task automatic send_beat(input bit s, input int m, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        prod_sign = s;
        prod_mag = m[MAG_W-1:0];
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL beat_ready: in_ready=%0b required 1 within 8 cycles", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        prod_sign = 1'($urandom);
        prod_mag = MAG_W'($urandom);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({out_valid, in_ready, busy, sat} !== 4'b0 || result !== '0) begin
            bad++;
            $display("FAIL reset_state: ov=%0b ir=%0b busy=%0b sat=%0b result=%0d required all 0",
                     out_valid, in_ready, busy, sat, res_val());
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_gaps();
        do_start(3);
        send_beat(1'b0, 100, 2);
        send_beat(1'b1, 30, 3);
        send_beat(1'b0, 5, 1);
        total++;
        if (out_valid !== 1'b1 || res_val() !== 75 || sat !== 1'b0) begin
            bad++;
            $display("FAIL gaps_result: ov=%0b result=%0d sat=%0b required ov=1 result=75 sat=0",
                     out_valid, res_val(), sat);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || res_val() !== 75) begin
            bad++;
            $display("FAIL gaps_handshake: ov=%0b busy=%0b result=%0d required ov=0 busy=0 result=75",
                     out_valid, busy, res_val());
        end
        $display("txn gaps len=3 result=%0d sat=%0b", res_val(), sat);
    endtask

    task automatic test_saturation();
        do_start(255);
        for (int i = 0; i < 255; i++) send_beat(1'b0, 65535, 0);
        total++;
        if (out_valid !== 1'b1 || res_val() !== 8388607 || sat !== 1'b1) begin
            bad++;
            $display("FAIL sat_pos: ov=%0b result=%0d sat=%0b required ov=1 result=8388607 sat=1",
                     out_valid, res_val(), sat);
        end
        $display("txn saturate len=255 result=%0d sat=%0b", res_val(), sat);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        do_start(2);
        send_beat(1'b1, 65535, 0);
        send_beat(1'b1, 65535, 1);
        total++;
        if (out_valid !== 1'b1 || res_val() !== -131070 || sat !== 1'b0) begin
            bad++;
            $display("FAIL sat_cleared: ov=%0b result=%0d sat=%0b required ov=1 result=-131070 sat=0",
                     out_valid, res_val(), sat);
        end
        $display("txn after_sat len=2 result=%0d sat=%0b", res_val(), sat);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_len_zero();
        bit ir_seen;
        ir_seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        len = '0;
        ir_seen |= in_ready;
        @(negedge clk);
        start = 1'b0;
        ir_seen |= in_ready;
        total++;
        if (out_valid !== 1'b1 || res_val() !== 0 || sat !== 1'b0) begin
            bad++;
            $display("FAIL len0_done: ov=%0b result=%0d sat=%0b required ov=1 result=0 sat=0",
                     out_valid, res_val(), sat);
        end
        out_ready = 1'b1;
        @(negedge clk);
        ir_seen |= in_ready;
        out_ready = 1'b0;
        total++;
        if (ir_seen !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL len0_ready: in_ready_seen=%0b ov=%0b required 0 and 0", ir_seen, out_valid);
        end
        $display("txn len0 result=%0d", res_val());
    endtask

    task automatic test_done_hold();
        do_start(2);
        send_beat(1'b0, 1000, 0);
        send_beat(1'b1, 3, 0);
        for (int c = 0; c < 5; c++) begin
            start = ~start;
            len = 8'd9;
            in_valid = 1'($urandom);
            prod_mag = MAG_W'($urandom);
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || res_val() !== 997 || sat !== 1'b0) begin
                bad++;
                $display("FAIL done_hold[%0d]: ov=%0b busy=%0b ir=%0b result=%0d sat=%0b required 1 1 0 997 0",
                         c, out_valid, busy, in_ready, res_val(), sat);
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_release: ov=%0b busy=%0b required 0 0", out_valid, busy);
        end
        $display("txn done_hold result=%0d", res_val());
    endtask

    task automatic test_reset_mid();
        do_start(4);
        send_beat(1'b0, 500, 0);
        send_beat(1'b0, 600, 0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready, busy, sat} !== 4'b0 || result !== '0) begin
            bad++;
            $display("FAIL async_reset: ov=%0b ir=%0b busy=%0b sat=%0b result=%0d required all 0",
                     out_valid, in_ready, busy, sat, res_val());
        end
        in_valid = 1'b1;
        prod_mag = 16'd77;
        prod_sign = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || result !== '0) begin
            bad++;
            $display("FAIL reset_release: busy=%0b result=%0d required 0 0", busy, res_val());
        end
        in_valid = 1'b0;
        do_start(1);
        send_beat(1'b1, 0, 0);
        total++;
        if (out_valid !== 1'b1 || res_val() !== 0 || sat !== 1'b0) begin
            bad++;
            $display("FAIL neg_zero: ov=%0b result=%0d sat=%0b required 1 0 0", out_valid, res_val(), sat);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        $display("txn reset_mid then len=1 result=%0d", res_val());
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        do_start(2);
        send_beat(1'b0, 7, 0);
        send_beat(1'b1, 7, 0);
        total++;
        if (out_valid !== 1'b1 || res_val() !== 0) begin
            bad++;
            $display("FAIL b2b_pulse: ov=%0b result=%0d required 1 0", out_valid, res_val());
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_single: ov=%0b busy=%0b required 0 0", out_valid, busy);
        end
        start = 1'b1;
        len = 8'd1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_start: ir=%0b busy=%0b required 1 1", in_ready, busy);
        end
        send_beat(1'b0, 42, 0);
        total++;
        if (out_valid !== 1'b1 || res_val() !== 42) begin
            bad++;
            $display("FAIL b2b_second: ov=%0b result=%0d required 1 42", out_valid, res_val());
        end
        @(negedge clk);
        out_ready = 1'b0;
        $display("txn back_to_back result=%0d", res_val());
    endtask

    task automatic test_random();
        for (int op = 0; op < 30; op++) begin
            int l;
            int bias;
            longint exp_acc;
            bit exp_sat;
            l = ($urandom_range(0, 3) == 0) ? $urandom_range(128, 255) : $urandom_range(1, 12);
            bias = $urandom_range(0, 2);
            exp_acc = 0;
            exp_sat = 1'b0;
            do_start(l);
            for (int b = 0; b < l; b++) begin
                bit s;
                int m;
                if (bias == 0) s = 1'($urandom);
                else if (bias == 1) s = ($urandom_range(0, 9) == 0);
                else s = ($urandom_range(0, 9) != 0);
                m = $urandom_range(0, 65535);
                exp_acc = model_add(exp_acc, s, longint'(m), exp_sat);
                send_beat(s, m, $urandom_range(0, 2));
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || res_val() !== exp_acc || sat !== exp_sat) begin
                bad++;
                $display("FAIL rand_op[%0d]: ov=%0b result=%0d sat=%0b required ov=1 result=%0d sat=%0b",
                         op, out_valid, res_val(), sat, exp_acc, exp_sat);
            end
            $display("txn random op=%0d len=%0d result=%0d sat=%0b", op, l, res_val(), sat);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_gaps();
        test_saturation();
        test_len_zero();
        test_done_hold();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ilm_accumulator.md
ILM_ACCUMULATOR -- requirements
Module: ilm_accumulator

Interface
- REQ-001: Parameter MAG_W, default 16, width of the unsigned product magnitude from the log multiplier.
- REQ-002: Parameter ACC_W, default 24, width of the signed two's-complement accumulator and result.
- REQ-003: Parameter LEN_W, default 8, width of the dot-product length field.
- REQ-004: clk  input  1  single clock; all state updates on its rising edge.
- REQ-005: rst_n  input  1  reset, asynchronous assert, active-low.
- REQ-006: start  input  1  one-cycle request to begin a new accumulation; sampled only in IDLE.
- REQ-007: len  input  LEN_W  number of products to accumulate; sampled with start.
- REQ-008: in_valid  input  1  product beat valid.
- REQ-009: in_ready  output  1  block accepts a product this cycle.
- REQ-010: prod_sign  input  1  product sign, 1 = negative.
- REQ-011: prod_mag  input  MAG_W  product magnitude, unsigned.
- REQ-012: out_valid  output  1  result is valid.
- REQ-013: out_ready  input  1  consumer accepts the result.
- REQ-014: result  output  ACC_W  signed accumulated sum.
- REQ-015: sat  output  1  sticky flag: saturation occurred during this accumulation.
- REQ-016: busy  output  1  high whenever state is not IDLE.

Function
- REQ-017: FSM states are IDLE, ACCUM and DONE.
- REQ-018: IDLE with start=1 and len!=0 moves to ACCUM, latches len into the remaining-beat counter, and clears the accumulator and sat.
- REQ-019: IDLE with start=1 and len==0 moves directly to DONE with result=0 and sat=0.
- REQ-020: start is ignored in ACCUM and DONE.
- REQ-021: in_ready is 1 only in ACCUM; in IDLE and DONE it is 0 and in_valid is ignored.
- REQ-022: A beat is accepted when in_valid and in_ready are both 1; prod_sign and prod_mag are valid on that cycle only.
- REQ-023: Accepted beat term = prod_mag zero-extended to ACC_W, negated if prod_sign=1; sign=1 with mag=0 contributes 0.
- REQ-024: acc_next = acc + term, computed at ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- REQ-025: Any clamp sets sat, which stays set until the next start.
- REQ-026: The remaining-beat counter decrements once per accepted beat; there is no decrement on stall cycles (in_valid=0).
- REQ-027: When the final beat is accepted, the FSM enters DONE on the next edge, and out_valid=1 with result equal to the acc including that beat (latency 1 cycle).
- REQ-028: In DONE, result and sat hold stable while out_valid=1 and out_ready=0.
- REQ-029: DONE with out_ready=1 returns to IDLE on that edge and out_valid falls; result keeps its last value until the next start.
- REQ-030: Back-to-back operation: start may be asserted on the first IDLE cycle after the handshake.

Reset
- REQ-031: rst_n=0 immediately, without waiting for a clock edge, sets IDLE, acc=0, counter=0, result=0, sat=0, out_valid=0, in_ready=0, busy=0.
- REQ-032: Reset asserted mid-ACCUM or in DONE discards the partial sum and any pending result; no beat is accepted on the reset-release edge.

Verification
- REQ-033: len=3; beats (+100, -30, +5) with in_valid gaps between them -> out_valid 1 cycle after third accept, result=75, sat=0.
- REQ-034: len=255; 255 beats of +65535 -> result=8388607, sat=1; then len=2 with beats (-65535, -65535) -> result=-131070, sat=0.
- REQ-035: len=0 start -> DONE next cycle, result=0, in_ready never high.
- REQ-036: In DONE, hold out_ready=0 for 5 cycles while toggling start, in_valid and prod_mag -> result, sat and state unchanged; out_ready=1 -> IDLE next cycle.
- REQ-037: Drop rst_n after 2 of 4 beats with len=4 -> outputs reach reset values asynchronously; a new len=1 beat of sign=1, mag=0 -> result=0.
- REQ-038: len=2, beats +7 and -7 with out_ready tied high -> out_valid is a single-cycle pulse with result=0, and start on the next cycle is accepted.
